fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage between the PC register and the decode stage. Each cycle it drives the PC register's next-value input, requests the instruction at the current PC from the instruction cache with a valid/ready handshake, and captures the result into the IF/ID pipeline register. It absorbs cache-miss latency, decode-side stalls (one-entry hold buffer) and branch redirects (flush), including a redirect that arrives while a miss is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, vector driven onto pc_next while reset is asserted
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc  in  32  current PC (PC register output)
- pc_next  out  32  combinational next PC (PC register input; PC loads every clk edge)
- icache_req  out  1  fetch request valid
- icache_addr  out  32  fetch address; stable while icache_req=1 and icache_ready=0
- icache_ready  in  1  response valid this cycle; completes the request
- icache_rdata  in  32  instruction word, valid with icache_ready
- stall  in  1  decode cannot accept; IF/ID must hold
- flush  in  1  redirect; squash everything younger
- redirect_pc  in  32  target PC, valid with flush
- ifid_valid  out  1  IF/ID holds a valid instruction
- ifid_pc  out  32  PC of ifid_instr
- ifid_instr  out  32  fetched instruction

## Operation
- States: FETCH, HOLD, SQUASH. Registers: state, ifid_{valid,pc,instr}, hold_{pc,instr}, sq_addr.
- Reset (rst_n=0): state=FETCH, ifid_valid=0, ifid_pc=0, ifid_instr=0, hold regs=0, sq_addr=0; icache_req forced 0; pc_next=RESET_PC. Reset must span at least one clk edge so that PC=RESET_PC on release.
- icache_req=1 in FETCH and SQUASH; icache_addr=pc in FETCH, sq_addr in SQUASH, pc in HOLD (don't-care).
- FETCH, ready=0, flush=0: pc_next=pc (hold), request held.
- FETCH, ready=0, flush=1: pc_next=redirect_pc, sq_addr<=pc, ->SQUASH.
- FETCH, ready=1, flush=1: data discarded, pc_next=redirect_pc, stay FETCH.
- FETCH, ready=1, flush=0, accept=(!ifid_valid||!stall): IF/ID<={1,pc,rdata}, pc_next=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0).
- FETCH, ready=1, flush=0, !accept: hold<={pc,rdata}, pc_next=pc+4, ->HOLD.
- HOLD: pc_next=pc, no request. flush=1: drop hold, pc_next=redirect_pc, ->FETCH. stall=0: IF/ID<={1,hold}, ->FETCH.
- SQUASH: pc_next=pc unless flush=1 (then pc_next=redirect_pc; sq_addr unchanged). ready=1: data discarded, ->FETCH.
- IF/ID update priority: flush (ifid_valid<=0) > stall&&ifid_valid (hold) > new load > bubble (ifid_valid<=0, pc/instr unchanged).
- Flush dominates stall and ready in every state.

## Timing
- Cache hit (ready in request cycle): 1 instruction/cycle; ifid_* visible 1 cycle after the ready edge; PC advances on the same edge.
- Miss of N wait cycles: pc held N cycles, ifid_valid=0 for those cycles unless stalled.
- Flush: ifid_valid=0 the following cycle; first redirected request issues the cycle after flush (FETCH) or the cycle after the stale response (SQUASH).
- HOLD->IF/ID transfer on the first edge with stall=0; next request issues the following cycle.
- Asynchronous reset mid-miss abandons the request (icache_req drops immediately); the cache must tolerate that.

## Test plan
- Reset release, hit every cycle, RESET_PC=0x100: ifid_pc 0x100,0x104,0x108… on consecutive cycles, ifid_valid=1 continuously from 2nd cycle.
- Miss: ready delayed 3 cycles at pc=0x104: pc held 0x104 for 3 cycles, icache_addr stable, ifid_valid=0 for 3 cycles, then ifid_pc=0x104.
- Stall with IF/ID full while hit returns 0xDEADBEEF at 0x108: ->HOLD, icache_req=0, ifid holds prior instr; stall drop -> ifid_instr=0xDEADBEEF, ifid_pc=0x108.
- Flush mid-miss (pc=0x200, redirect_pc=0x400): icache_addr stays 0x200 until ready, data discarded, next request 0x400, no instruction from 0x200 reaches IF/ID.
- Flush with stall=1 and ifid_valid=1, plus flush in HOLD: ifid_valid=0 next cycle, hold dropped, fetch resumes at redirect_pc.
- Wrap: pc=0xFFFF_FFFC hit -> pc_next=0x0000_0000; async reset asserted mid-miss -> icache_req=0 immediately, ifid_valid=0, pc_next=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC register's next value, requests words from the
// instruction cache, and fills the IF/ID register with miss, stall and redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic [31:0] icache_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] sq_addr_q, sq_addr_d;

  logic        load;
  logic [31:0] load_pc;
  logic [31:0] load_instr;
  logic [31:0] npc;
  logic        req;
  logic [31:0] addr;
  logic        accept;

  assign accept = !ifid_valid_q || !stall;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    sq_addr_d    = sq_addr_q;
    load         = 1'b0;
    load_pc      = ifid_pc_q;
    load_instr   = ifid_instr_q;
    npc          = pc;
    req          = 1'b0;
    addr         = pc;

    unique case (state_q)
      FETCH: begin
        req = 1'b1;
        if (flush) begin
          npc = redirect_pc;
          // The in-flight miss still has to drain; remember its address to keep it stable.
          if (!icache_ready) begin
            state_d   = SQUASH;
            sq_addr_d = pc;
          end
        end else if (icache_ready) begin
          npc = pc + 32'd4;
          if (accept) begin
            load       = 1'b1;
            load_pc    = pc;
            load_instr = icache_rdata;
          end else begin
            hold_pc_d    = pc;
            hold_instr_d = icache_rdata;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          npc     = redirect_pc;
          state_d = FETCH;
        end else if (!stall) begin
          load       = 1'b1;
          load_pc    = hold_pc_q;
          load_instr = hold_instr_q;
          state_d    = FETCH;
        end
      end
      SQUASH: begin
        req  = 1'b1;
        addr = sq_addr_q;
        if (flush) npc = redirect_pc;
        if (icache_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // IF/ID priority: flush, then stall of a valid entry, then a new load, else a bubble.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
    end else if (stall && ifid_valid_q) begin
      ifid_valid_d = 1'b1;
    end else if (load) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = load_pc;
      ifid_instr_d = load_instr;
    end else begin
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      sq_addr_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      sq_addr_q    <= sq_addr_d;
    end
  end

  // Reset acts on the outputs immediately, abandoning any outstanding request.
  assign pc_next     = rst_n ? npc : RESET_PC;
  assign icache_req  = rst_n && req;
  assign icache_addr = addr;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;

endmodule
